// File: rtl/axi_mem_pkg.sv
// Shared AXI encodings and write-port state type for the memory-side AXI ports.
package axi_mem_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      RESP
   } wr_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat byte address for FIXED/INCR/WRAP bursts.
// Shared by the write and read memory ports.
module axi_burst_addr_gen
   import axi_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] cur_addr,
   input  logic [2:0]            size,
   input  logic [7:0]            len,
   input  logic [1:0]            burst,
   output logic [ADDR_WIDTH-1:0] next_addr,
   output logic                  wrap_len_err
);

   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] incr_addr;
   logic [ADDR_WIDTH-1:0] wrap_mask;
   logic                  wrap_len_ok;

   always_comb begin
      step         = ADDR_WIDTH'(1) << size;
      incr_addr    = cur_addr + step;
      wrap_len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      wrap_mask    = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      wrap_len_err = (burst == AXI_BURST_WRAP) && !wrap_len_ok;
      next_addr    = incr_addr;
      case (burst)
         AXI_BURST_FIXED: next_addr = cur_addr;
         // an illegal wrap length degrades to INCR so the burst still completes
         AXI_BURST_WRAP:  next_addr = wrap_len_ok ? ((cur_addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                                  : incr_addr;
         default:         next_addr = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_write_mem_port.sv
// Wide-side AXI4 write slave: one AW/W burst at a time, one registered RAM write
// per accepted beat, B response with the burst ID once the last beat is taken.
//
// state | meaning
// IDLE  | awready high, waiting for a burst header
// DATA  | wready high, each beat becomes one RAM write
// RESP  | bvalid high, holding bid/bresp until bready
module axi_write_mem_port
   import axi_mem_pkg::*;
#(
   parameter int DATA_WIDTH        = 128,
   parameter int ADDR_WIDTH        = 32,
   parameter int ID_WIDTH          = 8,
   parameter int MEMORY_SIZE_BYTES = 4096,
   parameter int MEM_ADDR_WIDTH    = $clog2(MEMORY_SIZE_BYTES / (DATA_WIDTH / 8))
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [2:0]                s_axi_awsize,
   input  logic [7:0]                s_axi_awlen,
   input  logic [1:0]                s_axi_awburst,
   input  logic [ID_WIDTH-1:0]       s_axi_awid,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wlast,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [ID_WIDTH-1:0]       s_axi_bid,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);

   localparam int LOG2_BYTES = $clog2(DATA_WIDTH / 8);

   wr_state_t             state, state_nxt;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [2:0]            size_q;
   logic [7:0]            len_q;
   logic [1:0]            burst_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [7:0]            beat_cnt;
   logic                  err;
   logic                  size_err;
   logic                  wrap_len_err;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  last_beat;
   logic                  beat_oob;

   axi_burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .cur_addr     (cur_addr),
      .size         (size_q),
      .len          (len_q),
      .burst        (burst_q),
      .next_addr    (next_addr),
      .wrap_len_err (wrap_len_err)
   );

   assign aw_hs     = s_axi_awvalid && s_axi_awready;
   assign w_hs      = s_axi_wvalid && s_axi_wready;
   assign last_beat = (beat_cnt == len_q);
   assign beat_oob  = (cur_addr >= ADDR_WIDTH'(MEMORY_SIZE_BYTES));
   assign s_axi_bid   = id_q;
   assign s_axi_bresp = err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

   always_ff @(posedge aclk) begin
      if (areset) state <= IDLE;
      else        state <= state_nxt;
   end

   // handshake outputs are gated by areset so they are low even before the first edge
   always_comb begin
      state_nxt     = state;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      case (state)
         IDLE: begin
            s_axi_awready = !areset;
            if (s_axi_awvalid) state_nxt = DATA;
         end
         DATA: begin
            s_axi_wready = !areset;
            if (s_axi_wvalid && last_beat) state_nxt = RESP;
         end
         RESP: begin
            s_axi_bvalid = !areset;
            if (s_axi_bready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         cur_addr  <= '0;
         size_q    <= '0;
         len_q     <= '0;
         burst_q   <= '0;
         id_q      <= '0;
         beat_cnt  <= '0;
         err       <= 1'b0;
         size_err  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         mem_we <= 1'b0;
         if (aw_hs) begin
            cur_addr <= s_axi_awaddr;
            size_q   <= s_axi_awsize;
            len_q    <= s_axi_awlen;
            burst_q  <= s_axi_awburst;
            id_q     <= s_axi_awid;
            beat_cnt <= '0;
            err      <= 1'b0;
            size_err <= (s_axi_awsize > 3'(LOG2_BYTES));
         end
         if (w_hs) begin
            // beats are always consumed; only the RAM strobe is withheld on errors
            mem_we    <= !size_err && !beat_oob;
            mem_addr  <= cur_addr[MEM_ADDR_WIDTH+LOG2_BYTES-1 -: MEM_ADDR_WIDTH];
            mem_wdata <= s_axi_wdata;
            mem_wstrb <= s_axi_wstrb;
            beat_cnt  <= beat_cnt + 8'd1;
            cur_addr  <= next_addr;
            if (size_err || beat_oob || wrap_len_err || (s_axi_wlast != last_beat))
               err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi_write_mem_port.sv
// Scoreboard bench for axi_write_mem_port: directed cases plus randomized bursts
// checked against a byte-address reference model.
module tb_axi_write_mem_port;

   localparam int DW  = 128;
   localparam int AW  = 32;
   localparam int IW  = 8;
   localparam int MSB = 4096;
   localparam int MAW = 8;
   localparam int SW  = DW / 8;

   logic           aclk = 1'b0;
   logic           areset = 1'b1;
   logic [AW-1:0]  s_axi_awaddr = '0;
   logic [2:0]     s_axi_awsize = '0;
   logic [7:0]     s_axi_awlen = '0;
   logic [1:0]     s_axi_awburst = '0;
   logic [IW-1:0]  s_axi_awid = '0;
   logic           s_axi_awvalid = 1'b0;
   logic           s_axi_awready;
   logic [DW-1:0]  s_axi_wdata = '0;
   logic [SW-1:0]  s_axi_wstrb = '0;
   logic           s_axi_wlast = 1'b0;
   logic           s_axi_wvalid = 1'b0;
   logic           s_axi_wready;
   logic [IW-1:0]  s_axi_bid;
   logic [1:0]     s_axi_bresp;
   logic           s_axi_bvalid;
   logic           s_axi_bready = 1'b0;
   logic           mem_we;
   logic [MAW-1:0] mem_addr;
   logic [DW-1:0]  mem_wdata;
   logic [SW-1:0]  mem_wstrb;

   axi_write_mem_port #(
      .DATA_WIDTH        (DW),
      .ADDR_WIDTH        (AW),
      .ID_WIDTH          (IW),
      .MEMORY_SIZE_BYTES (MSB)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awsize  (s_axi_awsize),
      .s_axi_awlen   (s_axi_awlen),
      .s_axi_awburst (s_axi_awburst),
      .s_axi_awid    (s_axi_awid),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wlast   (s_axi_wlast),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bid     (s_axi_bid),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [MAW-1:0] addr;
      logic [DW-1:0]  data;
      logic [SW-1:0]  strb;
   } wr_t;

   typedef struct {
      logic [IW-1:0] id;
      logic [1:0]    resp;
   } b_t;

   wr_t exp_wr[$];
   b_t  exp_b[$];
   wr_t mon_w;
   b_t  mon_b;
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  aw_cyc = 0;
   bit  timing_chk = 1'b0;
   int  exp_lat = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor: at the falling edge, mem_we reflects last cycle's beat and a
   // pending valid&&ready pair is the handshake of the next rising edge.
   always @(negedge aclk) begin
      if (s_axi_awvalid && s_axi_awready) aw_cyc = cyc;
      if (mem_we === 1'b1) begin
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%0h required=none", mem_addr);
         end else begin
            mon_w = exp_wr.pop_front();
            chk("wr_addr", 128'(mem_addr), 128'(mon_w.addr));
            chk("wr_data", 128'(mem_wdata), 128'(mon_w.data));
            chk("wr_strb", 128'(mem_wstrb), 128'(mon_w.strb));
         end
      end
      if (s_axi_bvalid === 1'b1 && s_axi_bready === 1'b1) begin
         if (exp_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_b actual=%0h required=none", s_axi_bid);
         end else begin
            mon_b = exp_b.pop_front();
            chk("b_id", 128'(s_axi_bid), 128'(mon_b.id));
            chk("b_resp", 128'(s_axi_bresp), 128'(mon_b.resp));
         end
         if (timing_chk) begin
            chk("aw_to_b_cycles", 128'(cyc - aw_cyc), 128'(exp_lat));
            timing_chk = 1'b0;
         end
      end
   end

   function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst,
                                              input logic [31:0] i);
      logic [31:0] step, wb, base;
      step = 32'd1 << size;
      if (burst == 2'b00) return a;
      if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
         wb   = step * (32'(len) + 32'd1);
         base = a - (a % wb);
         return base + ((a - base + step * i) % wb);
      end
      return a + step * i;
   endfunction

   task automatic send_aw(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                          input logic [1:0] burst, input logic [7:0] id);
      int n;
      @(posedge aclk);
      #1;
      s_axi_awaddr  = addr;
      s_axi_awsize  = size;
      s_axi_awlen   = len;
      s_axi_awburst = burst;
      s_axi_awid    = id;
      s_axi_awvalid = 1'b1;
      n = 0;
      @(negedge aclk);
      while (!s_axi_awready && n < 100) begin
         @(negedge aclk);
         n++;
      end
      if (!s_axi_awready) begin
         checks++;
         errors++;
         $display("FAIL aw_timeout actual=0 required=1");
      end
      @(posedge aclk);
      #1;
      s_axi_awvalid = 1'b0;
   endtask

   // entered and left at posedge+1
   task automatic send_beat(input int gap, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input logic last);
      int n;
      if (gap > 0) begin
         s_axi_wvalid = 1'b0;
         repeat (gap) @(posedge aclk);
         #1;
      end
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = d;
      s_axi_wstrb  = s;
      s_axi_wlast  = last;
      n = 0;
      @(negedge aclk);
      while (!s_axi_wready && n < 100) begin
         @(negedge aclk);
         n++;
      end
      if (!s_axi_wready) begin
         checks++;
         errors++;
         $display("FAIL w_timeout actual=0 required=1");
      end
      @(posedge aclk);
      #1;
      s_axi_wvalid = 1'b0;
   endtask

   task automatic do_burst(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                           input logic [1:0] burst, input logic [7:0] id, input int bad_beat,
                           input bit rnd, input logic [DW-1:0] dbase, input logic [SW-1:0] strb_c,
                           input int bready_dly);
      logic [DW-1:0] dq[$];
      logic [SW-1:0] sq[$];
      logic [31:0]   a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic          err;
      b_t            eb;
      wr_t           ew;
      int            n;

      err = (size > 3'd4) || (bad_beat >= 0 && bad_beat <= int'(len)) ||
            (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
      for (int i = 0; i <= int'(len); i++) begin
         if (rnd) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            s = SW'($urandom);
         end else begin
            d = dbase + DW'(i);
            s = strb_c;
         end
         dq.push_back(d);
         sq.push_back(s);
         a = model_addr(addr, size, len, burst, 32'(i));
         if (a >= 32'(MSB)) err = 1'b1;
         else if (size <= 3'd4) begin
            ew.addr = a[11:4];
            ew.data = d;
            ew.strb = s;
            exp_wr.push_back(ew);
         end
      end
      eb.id   = id;
      eb.resp = err ? 2'b10 : 2'b00;
      exp_b.push_back(eb);

      s_axi_bready = (bready_dly == 0);
      send_aw(addr, size, len, burst, id);
      for (int i = 0; i <= int'(len); i++)
         send_beat(rnd ? $urandom_range(0, 2) : 0, dq[i], sq[i], (i == int'(len)) ^ (i == bad_beat));

      n = 0;
      @(negedge aclk);
      while (!s_axi_bvalid && n < 100) begin
         @(negedge aclk);
         n++;
      end
      if (!s_axi_bvalid) begin
         checks++;
         errors++;
         $display("FAIL b_timeout actual=0 required=1");
      end
      if (bready_dly > 0) begin
         for (int k = 0; k < bready_dly; k++) begin
            chk("b_hold_valid", 128'(s_axi_bvalid), 128'(1));
            chk("b_hold_id", 128'(s_axi_bid), 128'(id));
            chk("b_hold_resp", 128'(s_axi_bresp), 128'(eb.resp));
            chk("awready_in_resp", 128'(s_axi_awready), 128'(0));
            @(negedge aclk);
         end
         @(posedge aclk);
         #1;
         s_axi_bready = 1'b1;
         @(negedge aclk);
      end
      @(posedge aclk);
      #1;
      s_axi_bready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [7:0] rlen;
      logic [1:0] rburst;
      logic [2:0] rsize;
      int         bad;

      // reset
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk("rst_awready", 128'(s_axi_awready), 128'(0));
      chk("rst_wready", 128'(s_axi_wready), 128'(0));
      chk("rst_bvalid", 128'(s_axi_bvalid), 128'(0));
      chk("rst_mem_we", 128'(mem_we), 128'(0));
      chk("rst_mem_addr", 128'(mem_addr), 128'(0));
      @(posedge aclk);
      #1;
      areset = 1'b0;
      @(negedge aclk);
      chk("idle_awready", 128'(s_axi_awready), 128'(1));
      chk("idle_bresp", 128'(s_axi_bresp), 128'(0));

      // INCR with latency measurement
      exp_lat    = 5;
      timing_chk = 1'b1;
      do_burst(32'h100, 3'd4, 8'd3, 2'b01, 8'h5A, -1, 1'b0, 128'hA0, 16'hFFFF, 0);
      chk("timing_consumed", 128'(timing_chk), 128'(0));
      timing_chk = 1'b0;

      // WRAP
      do_burst(32'h230, 3'd4, 8'd3, 2'b10, 8'h11, -1, 1'b0, 128'hB0, 16'hFFFF, 0);
      // FIXED narrow
      do_burst(32'h40, 3'd2, 8'd2, 2'b00, 8'h22, -1, 1'b0, 128'hC0, 16'h000F, 0);
      // early wlast
      do_burst(32'h0, 3'd4, 8'd3, 2'b01, 8'h33, 1, 1'b0, 128'hD0, 16'hFFFF, 0);
      // oversize beat
      do_burst(32'h0, 3'd5, 8'd1, 2'b01, 8'h44, -1, 1'b0, 128'hE0, 16'hFFFF, 0);
      // out of range second beat, B backpressure
      do_burst(32'hFF0, 3'd4, 8'd1, 2'b01, 8'h55, -1, 1'b0, 128'hF0, 16'hFFFF, 5);

      // reset after beat 1 of an 8-beat burst
      exp_wr.push_back('{addr: 8'h00, data: 128'h1, strb: 16'hFFFF});
      exp_wr.push_back('{addr: 8'h01, data: 128'h2, strb: 16'hFFFF});
      send_aw(32'h0, 3'd4, 8'd7, 2'b01, 8'h66);
      send_beat(0, 128'h1, 16'hFFFF, 1'b0);
      send_beat(0, 128'h2, 16'hFFFF, 1'b0);
      areset = 1'b1;
      @(posedge aclk);
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         chk("midrst_mem_we", 128'(mem_we), 128'(0));
         chk("midrst_bvalid", 128'(s_axi_bvalid), 128'(0));
      end
      @(posedge aclk);
      #1;
      areset = 1'b0;
      do_burst(32'h80, 3'd4, 8'd0, 2'b01, 8'h77, -1, 1'b0, 128'h99, 16'hFFFF, 0);

      // randomized bursts
      for (int t = 0; t < 40; t++) begin
         rburst = 2'($urandom_range(0, 2));
         rsize  = ($urandom_range(0, 9) == 0) ? 3'd5 : 3'($urandom_range(0, 4));
         if (rburst == 2'b10 && $urandom_range(0, 4) != 0)
            rlen = 8'((1 << $urandom_range(1, 4)) - 1);
         else
            rlen = 8'($urandom_range(0, 15));
         bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, int'(rlen)) : -1;
         do_burst($urandom_range(0, 32'h1100), rsize, rlen, rburst, 8'($urandom), bad, 1'b1,
                  '0, '0, $urandom_range(0, 3));
      end

      repeat (3) @(negedge aclk);
      chk("wr_queue_empty", 128'(exp_wr.size()), 128'(0));
      chk("b_queue_empty", 128'(exp_b.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
